// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_if
//  Description : Handshake and register-file write bundle for the write-port
//                arbiter. The requester side (master) drives the two request
//                channels and observes readies plus the registered write-port
//                controls. The arbiter side (slave) drives the readies and
//                the write-port controls.
//  Signals     : req_valid_x/req_reg_x/req_data_x/req_ready_x (x = a, b),
//                ctrl_writeEnable, ctrl_writeReg, data_writeReg, last_grant
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5
);
  logic                  req_valid_a;
  logic [REG_BITS-1:0]   req_reg_a;
  logic [DATA_WIDTH-1:0] req_data_a;
  logic                  req_ready_a;

  logic                  req_valid_b;
  logic [REG_BITS-1:0]   req_reg_b;
  logic [DATA_WIDTH-1:0] req_data_b;
  logic                  req_ready_b;

  logic                  ctrl_writeEnable;
  logic [REG_BITS-1:0]   ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic                  last_grant;

  modport master (
    output req_valid_a, req_reg_a, req_data_a,
    output req_valid_b, req_reg_b, req_data_b,
    input  req_ready_a, req_ready_b,
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, last_grant
  );

  modport slave (
    input  req_valid_a, req_reg_a, req_data_a,
    input  req_valid_b, req_reg_b, req_data_b,
    output req_ready_a, req_ready_b,
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, last_grant
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single register-file write port between two
//                writeback requesters. Each port owns a one-entry holding
//                buffer; a round-robin arbiter issues one buffered write per
//                cycle onto registered write-port controls. Writes to
//                register 0 complete their handshake but raise no strobe.
//  Ports       : clock      - rising-edge clock
//                ctrl_reset - synchronous active-high reset
//                bus        - slave side of regfile_write_arbiter_if
//                             (request channels A/B, write-port controls,
//                             last_grant)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_BITS      = 5,
  parameter int PRIORITY_INIT = 0
) (
  input  wire                     clock,
  input  wire                     ctrl_reset,
  regfile_write_arbiter_if.slave  bus
);

  // Reset value of last_grant: the opposite of the port that should win the
  // first tie.
  localparam logic C_LAST_GRANT_RST = (PRIORITY_INIT == 0) ? 1'b1 : 1'b0;

  // Holding buffers
  logic                  full_a_q, full_a_d;
  logic [REG_BITS-1:0]   reg_a_q,  reg_a_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic                  full_b_q, full_b_d;
  logic [REG_BITS-1:0]   reg_b_q,  reg_b_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;

  // Arbiter history and registered write-port controls
  logic                  last_grant_q, last_grant_d;
  logic                  we_q,    we_d;
  logic [REG_BITS-1:0]   wreg_q,  wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic grant_a, grant_b;
  logic ready_a, ready_b;
  logic accept_a, accept_b;

  // Round-robin grant over the buffers: on a tie the port that did not win
  // last time is served.
  always_comb begin
    grant_a = full_a_q && (!full_b_q || last_grant_q);
    grant_b = full_b_q && (!full_a_q || !last_grant_q);
  end

  // A buffer being drained this edge can be refilled in the same edge, which
  // is what lets a single streaming port sustain one write per cycle.
  always_comb begin
    ready_a  = !ctrl_reset && (!full_a_q || grant_a);
    ready_b  = !ctrl_reset && (!full_b_q || grant_b);
    accept_a = bus.req_valid_a && ready_a;
    accept_b = bus.req_valid_b && ready_b;
  end

  always_comb begin
    full_a_d     = full_a_q;
    reg_a_d      = reg_a_q;
    data_a_d     = data_a_q;
    full_b_d     = full_b_q;
    reg_b_d      = reg_b_q;
    data_b_d     = data_b_q;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;

    // Buffer A: a new accept overrides the drain-clear
    if (accept_a) begin
      full_a_d = 1'b1;
      reg_a_d  = bus.req_reg_a;
      data_a_d = bus.req_data_a;
    end else if (grant_a) begin
      full_a_d = 1'b0;
    end

    // Buffer B
    if (accept_b) begin
      full_b_d = 1'b1;
      reg_b_d  = bus.req_reg_b;
      data_b_d = bus.req_data_b;
    end else if (grant_b) begin
      full_b_d = 1'b0;
    end

    // Issue: register 0 still loads the index/data but never strobes
    if (grant_a) begin
      last_grant_d = 1'b0;
      we_d         = (reg_a_q != '0);
      wreg_d       = reg_a_q;
      wdata_d      = data_a_q;
    end else if (grant_b) begin
      last_grant_d = 1'b1;
      we_d         = (reg_b_q != '0);
      wreg_d       = reg_b_q;
      wdata_d      = data_b_q;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      full_a_q     <= 1'b0;
      reg_a_q      <= '0;
      data_a_q     <= '0;
      full_b_q     <= 1'b0;
      reg_b_q      <= '0;
      data_b_q     <= '0;
      last_grant_q <= C_LAST_GRANT_RST;
      we_q         <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
    end else begin
      full_a_q     <= full_a_d;
      reg_a_q      <= reg_a_d;
      data_a_q     <= data_a_d;
      full_b_q     <= full_b_d;
      reg_b_q      <= reg_b_d;
      data_b_q     <= data_b_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.req_ready_a      = ready_a;
  assign bus.req_ready_b      = ready_b;
  assign bus.ctrl_writeEnable = we_q;
  assign bus.ctrl_writeReg    = wreg_q;
  assign bus.data_writeReg    = wdata_q;
  assign bus.last_grant       = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic clock = 1'b0;
  logic ctrl_reset;

  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DATA_WIDTH(32), .REG_BITS(5)) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH   (32),
    .REG_BITS     (5),
    .PRIORITY_INIT(0)
  ) u_dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Request queues per port and the strobe log of the last run
  logic [4:0]  qa_reg[$];
  logic [31:0] qa_dat[$];
  logic [4:0]  qb_reg[$];
  logic [31:0] qb_dat[$];
  logic [4:0]  s_reg[$];
  logic [31:0] s_dat[$];
  logic        s_lg[$];
  int          s_cyc[$];
  int          n_acc_a, n_acc_b;
  int          first_acc_b, last_acc_b;

  task automatic clear_queues();
    qa_reg.delete(); qa_dat.delete(); qb_reg.delete(); qb_dat.delete();
    s_reg.delete(); s_dat.delete(); s_lg.delete(); s_cyc.delete();
  endtask

  // Presents queued requests with valid held until accepted; iteration i ends
  // with edge i. Strobes seen after edge i are logged with cycle i.
  task automatic run(input int ncyc);
    logic acc_a, acc_b;
    n_acc_a = 0; n_acc_b = 0; first_acc_b = -1; last_acc_b = -1;
    for (int i = 0; i < ncyc; i++) begin
      bus.req_valid_a = (n_acc_a < qa_reg.size());
      bus.req_reg_a   = bus.req_valid_a ? qa_reg[n_acc_a] : 5'd0;
      bus.req_data_a  = bus.req_valid_a ? qa_dat[n_acc_a] : 32'd0;
      bus.req_valid_b = (n_acc_b < qb_reg.size());
      bus.req_reg_b   = bus.req_valid_b ? qb_reg[n_acc_b] : 5'd0;
      bus.req_data_b  = bus.req_valid_b ? qb_dat[n_acc_b] : 32'd0;
      #1;
      acc_a = bus.req_valid_a && bus.req_ready_a;
      acc_b = bus.req_valid_b && bus.req_ready_b;
      @(posedge clock); #1;
      if (acc_a) n_acc_a++;
      if (acc_b) begin
        n_acc_b++;
        if (first_acc_b < 0) first_acc_b = i;
        last_acc_b = i;
      end
      if (bus.ctrl_writeEnable) begin
        s_reg.push_back(bus.ctrl_writeReg);
        s_dat.push_back(bus.data_writeReg);
        s_lg.push_back(bus.last_grant);
        s_cyc.push_back(i);
      end
    end
    bus.req_valid_a = 1'b0;
    bus.req_valid_b = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_reg [6];
    logic       exp_lg  [6];

    bus.req_valid_a = 1'b0; bus.req_reg_a = '0; bus.req_data_a = '0;
    bus.req_valid_b = 1'b0; bus.req_reg_b = '0; bus.req_data_b = '0;

    // ---------------- Reset state: 2 cycles with both valids high
    ctrl_reset = 1'b1;
    bus.req_valid_a = 1'b1; bus.req_reg_a = 5'd3; bus.req_data_a = 32'h33;
    bus.req_valid_b = 1'b1; bus.req_reg_b = 5'd4; bus.req_data_b = 32'h44;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      check_eq("rst_ready_a", bus.req_ready_a, 1'b0);
      check_eq("rst_ready_b", bus.req_ready_b, 1'b0);
      check_eq("rst_we", bus.ctrl_writeEnable, 1'b0);
      check_eq("rst_wreg", bus.ctrl_writeReg, 5'd0);
      check_eq("rst_wdata", bus.data_writeReg, 32'd0);
      check_eq("rst_last_grant", bus.last_grant, 1'b1);
    end
    bus.req_valid_a = 1'b0; bus.req_valid_b = 1'b0;
    ctrl_reset = 1'b0;
    #1;
    check_eq("post_rst_ready_a", bus.req_ready_a, 1'b1);
    check_eq("post_rst_ready_b", bus.req_ready_b, 1'b1);

    // ---------------- Contention: A 1,2,3 / B 11,12,13, A wins first tie
    clear_queues();
    qa_reg = '{5'd1, 5'd2, 5'd3};    qa_dat = '{32'h101, 32'h102, 32'h103};
    qb_reg = '{5'd11, 5'd12, 5'd13}; qb_dat = '{32'h20B, 32'h20C, 32'h20D};
    exp_reg = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
    exp_lg  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run(10);
    check_eq("cont_count", s_reg.size(), 6);
    check_eq("cont_accept_a", n_acc_a, 3);
    check_eq("cont_accept_b", n_acc_b, 3);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("cont_reg%0d", k), s_reg[k], exp_reg[k]);
      check_eq($sformatf("cont_lg%0d", k), s_lg[k], exp_lg[k]);
      check_eq($sformatf("cont_cyc%0d", k), s_cyc[k], k + 1);
    end
    check_eq("cont_dat1", s_dat[1], 32'h20B);
    check_eq("cont_dat4", s_dat[4], 32'h103);

    // ---------------- Single write: A reg 5 = DEADBEEF, one strobe cycle
    clear_queues();
    qa_reg = '{5'd5}; qa_dat = '{32'hDEADBEEF};
    run(4);
    check_eq("single_count", s_reg.size(), 1);
    check_eq("single_cyc", s_cyc[0], 1);
    check_eq("single_reg", s_reg[0], 5'd5);
    check_eq("single_dat", s_dat[0], 32'hDEADBEEF);
    check_eq("single_we_after", bus.ctrl_writeEnable, 1'b0);
    check_eq("single_hold_reg", bus.ctrl_writeReg, 5'd5);

    // ---------------- Register 0: handshake completes, no strobe
    clear_queues();
    qa_reg = '{5'd0}; qa_dat = '{32'h1234};
    run(4);
    check_eq("r0_accepted", n_acc_a, 1);
    check_eq("r0_no_strobe", s_reg.size(), 0);
    check_eq("r0_wreg", bus.ctrl_writeReg, 5'd0);
    check_eq("r0_wdata", bus.data_writeReg, 32'h1234);
    check_eq("r0_last_grant", bus.last_grant, 1'b0);

    // ---------------- Streaming: B regs 1..8, no ready bubble
    clear_queues();
    for (int r = 1; r <= 8; r++) begin
      qb_reg.push_back(5'(r));
      qb_dat.push_back(32'h5000 + 32'(r));
    end
    run(11);
    check_eq("stream_count", s_reg.size(), 8);
    check_eq("stream_accepts", n_acc_b, 8);
    check_eq("stream_no_bubble", last_acc_b - first_acc_b, 7);
    check_eq("stream_first_cyc", s_cyc[0], 1);
    check_eq("stream_last_cyc", s_cyc[7], 8);
    check_eq("stream_reg7", s_reg[7], 5'd8);
    check_eq("stream_dat3", s_dat[3], 32'h5004);

    // ---------------- Same target reg 7: A (0xA) wins tie, then B (0xB)
    clear_queues();
    qa_reg = '{5'd7}; qa_dat = '{32'hA};
    qb_reg = '{5'd7}; qb_dat = '{32'hB};
    run(5);
    check_eq("same_count", s_reg.size(), 2);
    check_eq("same_reg0", s_reg[0], 5'd7);
    check_eq("same_dat0", s_dat[0], 32'hA);
    check_eq("same_reg1", s_reg[1], 5'd7);
    check_eq("same_dat1", s_dat[1], 32'hB);

    // ---------------- Mid-stream reset with both buffers full
    bus.req_valid_a = 1'b1; bus.req_reg_a = 5'd20; bus.req_data_a = 32'hAAAA;
    bus.req_valid_b = 1'b1; bus.req_reg_b = 5'd21; bus.req_data_b = 32'hBBBB;
    @(posedge clock); #1;
    bus.req_valid_a = 1'b0; bus.req_valid_b = 1'b0;
    check_eq("mid_full_ready_a", bus.req_ready_a, 1'b1);
    check_eq("mid_full_ready_b", bus.req_ready_b, 1'b0);
    ctrl_reset = 1'b1;
    #1;
    check_eq("mid_rst_ready_a", bus.req_ready_a, 1'b0);
    @(posedge clock); #1;
    check_eq("mid_rst_we", bus.ctrl_writeEnable, 1'b0);
    ctrl_reset = 1'b0;
    @(posedge clock); #1;
    check_eq("mid_post_we", bus.ctrl_writeEnable, 1'b0);
    clear_queues();
    qa_reg = '{5'd9}; qa_dat = '{32'h99};
    run(4);
    check_eq("mid_after_count", s_reg.size(), 1);
    check_eq("mid_after_reg", s_reg[0], 5'd9);
    check_eq("mid_after_dat", s_dat[0], 32'h99);
    check_eq("mid_after_cyc", s_cyc[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32 register file between two independent writeback requesters (port A, port B) using valid/ready handshakes. Each port has a one-entry holding buffer. A round-robin arbiter grants one buffered write per cycle and drives registered `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg` straight into the register file. Writes that target register 0 complete their handshake but are dropped, so no write strobe is issued for them.

## Interface
- `DATA_WIDTH`, default 32, write data width.
- `REG_BITS`, default 5, register index width (2^REG_BITS registers).
- `PRIORITY_INIT`, default 0, port that wins the first tie after reset (0 = A, 1 = B).

- `clock`  in  1  single clock; all state updates on rising edge.
- `ctrl_reset`  in  1  reset, synchronous and active-high.
- `req_valid_a`  in  1  port A holds a write request.
- `req_reg_a`  in  REG_BITS  port A target register.
- `req_data_a`  in  DATA_WIDTH  port A write data.
- `req_ready_a`  out  1  port A request accepted at this edge if valid.
- `req_valid_b`, `req_reg_b`, `req_data_b`, `req_ready_b`: same as port A, for port B.
- `ctrl_writeEnable`  out  1  register-file write strobe (registered).
- `ctrl_writeReg`  out  REG_BITS  register-file write index (registered).
- `data_writeReg`  out  DATA_WIDTH  register-file write data (registered).
- `last_grant`  out  1  port granted most recently (0 = A, 1 = B).

## Operation
- **Per-port buffer.** Each port has a buffer holding {full, reg, data}.
  - `req_ready_x` = !ctrl_reset && (!full_x || grant_x), computed combinationally.
  - Accept occurs when `req_valid_x && req_ready_x`. At the edge, the buffer loads reg/data and full_x is set to 1.
- **Arbitration** is combinational over the buffers:
  - Only A full: grant A.
  - Only B full: grant B.
  - Both full: grant the port ≠ `last_grant`.
  - Neither full: no grant.
- **Effect of a grant** at an edge:
  - full_x clears, unless the same port accepts a new request at that edge, in which case full_x stays 1 with the new contents.
  - `last_grant` updates to the granted port.
  - The output registers load the granted reg/data.
  - `ctrl_writeEnable` is set to 1 if reg ≠ 0, and to 0 if reg = 0 (dropped write).
- **No grant** at an edge: `ctrl_writeEnable` goes to 0. `ctrl_writeReg` and `data_writeReg` hold their previous values.
- **Same target register.** When A and B target the same register, both writes are issued in grant order. The register file ends with the later-granted data.
- **Ordering.** Within one port, writes reach the register file in acceptance order. Nothing is ever reordered or dropped, except writes to register 0.
- **Reset.** While `ctrl_reset` is high, at each edge:
  - both buffers empty;
  - `ctrl_writeEnable` = 0, `ctrl_writeReg` = 0, `data_writeReg` = 0;
  - `last_grant` = !PRIORITY_INIT, so PRIORITY_INIT wins the first tie;
  - both readies are 0.
  - Reset mid-operation discards buffered, unissued writes.
  - A strobe already registered in the cycle before reset asserts is still presented for that cycle.

## Timing
- **Accept-to-strobe latency.** Request accepted at edge k, buffer granted at edge k+1, `ctrl_writeEnable` high during the cycle after edge k+1. The register file captures the data at edge k+2.
- **Throughput.** One write per cycle total.
  - A single continuously valid port sustains one write per cycle, because ready stays high while its buffer is being granted.
  - With both ports continuously valid, grants alternate A, B, A, B… Each port then sees ready high on alternate cycles.
- **Stall.** A full, non-granted buffer holds `req_ready_x` = 0. The requester must hold valid, reg and data stable until accepted.
- **First ready after reset.** Readies become 1 in the first cycle after `ctrl_reset` deasserts.
- **Output path.** Outputs are registered, so there is no combinational path from any request input to the register-file controls.

## Test plan
- **Reset state.** Hold `ctrl_reset` for 2 cycles with both valids high. Required: readies = 0; all outputs = 0; `last_grant` = 1 (PRIORITY_INIT = 0); no strobe.
- **Single write.** A writes reg 5 = 0xDEADBEEF, accepted at edge k. Required: `ctrl_writeEnable` = 1, `ctrl_writeReg` = 5, `data_writeReg` = 0xDEADBEEF in the cycle after edge k+1 only; then `ctrl_writeEnable` = 0.
- **Contention.** A and B both valid for 6 cycles (A: regs 1,2,3; B: regs 11,12,13), accepted together at edge k. Required: strobes on consecutive cycles to regs 1,11,2,12,3,13; `last_grant` toggles each cycle.
- **Streaming.** B alone streams regs 1..8 with valid held high. Required: 8 consecutive strobes, one per cycle, with no ready bubble after the first accept.
- **Register 0 and same target.** A writes reg 0 = 0x1234, then A and B both target reg 7 (A = 0xA, B = 0xB) with A winning the tie. Required: the reg 0 handshake completes with no strobe; two strobes to reg 7, 0xA then 0xB.
- **Mid-stream reset.** Assert `ctrl_reset` while both buffers are full. Required: no strobe for the buffered entries after the edge; post-reset, the first write is accepted and strobed normally.
